router_pkt_framer: RTL and testbench
====================================

# router_pkt_framer

Upstream source stage for `router_1x3`: accepts a packet request (destination, length) and a payload byte stream over valid/ready handshakes and buffers the whole payload. It then emits the router's input framing on `pkt_valid`/`pkt_data`: the header, contiguous payload bytes, and a parity byte with `pkt_valid` low. Buffering guarantees the router never sees a bubble inside a packet, whatever upstream stalls occur.

## Interface
- `LEN_MAX`, 16: maximum payload bytes per packet (buffer depth).
- `LEN_W`, 5: width of `start_len`; must hold `LEN_MAX`.
- `HDR_CYCLES`, 2: cycles the header is held on `pkt_data`.
- `IPG`, 3: idle cycles after parity before the next request is accepted.

Ports:
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `start_valid` in 1: packet request valid.
- `start_ready` out 1: request accepted when high with `start_valid`.
- `start_dest` in 2: destination port, 0..2; 3 is illegal.
- `start_len` in `LEN_W`: payload length, 1..`LEN_MAX`.
- `pl_valid` in 1: payload byte valid.
- `pl_ready` out 1: payload byte accepted when high with `pl_valid`.
- `pl_data` in 8: payload byte.
- `err_inj` in 1: corrupt parity of the current packet. Present only with `ROUTER_FRAMER_ERR_INJ_EN`.
- `pkt_valid` out 1: router `pkt_valid`.
- `pkt_data` out 8: router `data_in`.
- `pkt_done` out 1: one-cycle pulse on the parity cycle.
- `drop_err` out 1: one-cycle pulse when a request is rejected.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, LOAD, HDR, PAY, PAR, GAP.
- **IDLE**
  - `start_ready`=1.
  - On handshake with `start_dest`=3 or `start_len`=0 or `start_len`>`LEN_MAX`: pulse `drop_err` next cycle and stay in IDLE.
  - Otherwise latch dest and len, set header = {6'b101010, dest}, seed the parity accumulator with the header, and go to LOAD.
- **LOAD**
  - `pl_ready`=1.
  - Each accepted byte is pushed into the buffer and XORed into the parity accumulator.
  - After the len-th byte, go to HDR.
- **HDR**: `pkt_valid`=1, `pkt_data`=header for `HDR_CYCLES` cycles.
- **PAY**: `pkt_valid`=1, one buffered byte per cycle for len cycles, no gaps.
- **PAR**: `pkt_valid`=0, `pkt_data`=parity, `pkt_done`=1 for one cycle.
- **GAP**: `pkt_valid`=0, `pkt_data`=0 for `IPG` cycles, then IDLE.
- `pl_ready` is 0 outside LOAD. `start_ready` is 0 outside IDLE.
- Parity is the 8-bit XOR of the header and all payload bytes.
- The length counter is `LEN_W` bits and counts down to zero; the buffer pointers wrap modulo `LEN_MAX`. A full buffer is unreachable by construction.

## Timing
- Reset values: `pkt_valid`=0, `pkt_data`=0, `pkt_done`=0, `drop_err`=0, `busy`=0, `start_ready`=1, `pl_ready`=0. State is IDLE and the buffer is empty.
- Reset asserted mid-packet aborts immediately; outputs return to reset values asynchronously.
- `pkt_valid`, `pkt_data`, `pkt_done` and `drop_err` are registered outputs.
- Last payload handshake at cycle M → header on `pkt_data` from M+1.
- Per-packet output span: `HDR_CYCLES` + len + 1 cycles, then `IPG`.
- Request accepted at cycle N → `pl_ready` high from N+1.
- `pl_valid` low during LOAD only stretches LOAD; output timing is unaffected.
- A request arriving during any non-IDLE state is held off by `start_ready`=0.

## Configuration
- `ROUTER_FRAMER_ERR_INJ_EN` defined:
  - `err_inj` port exists and is sampled on the request handshake.
  - If set, the emitted parity is bitwise inverted (~parity) for that packet.
- Undefined: the port is absent and parity is always correct.

## Structure
- `router_pkg` holds:
  - `HDR_TAG` = 6'b101010 and `DEST_INVALID` = 2'd3.
  - The framer state enum typedef.
  - A header-build function.
- Sub-module `router_framer_fifo`: synchronous 8-bit FIFO, depth `LEN_MAX`, with push/pop and empty flag. It is cleared by `resetn`.

## Test plan
- Dest 2, len 5, bytes 11,22,33,44,55 (hex) → `pkt_data` AA, AA, 11, 22, 33, 44, 55 with `pkt_valid`=1, then BB with `pkt_valid`=0 and `pkt_done`=1.
- Macro defined, `err_inj`=1, dest 1, len 1, byte 00 → A9, A9, 00, then parity 56 (not A9).
- Dest 3, len 4 → `drop_err` pulses once; `pkt_valid` stays 0; `pl_ready` never rises; next legal request is accepted.
- Dest 0, len 3 with `pl_valid` toggling 1,0,0,1,0,1 → output bytes contiguous, header A8, parity = A8^b0^b1^b2.
- Dest 2, len 16, all bytes FF → 16 contiguous FF bytes, parity AA.
- `resetn` pulsed low during PAY → `pkt_valid` drops at once. A following dest 1, len 2 packet (01, 02) emits A9, A9, 01, 02, then parity AA.

Source files
------------

// File: rtl/router_pkg.sv
// router_pkg: shared tags, framer state encoding and header builder
// for the router_1x3 packet framer slice.
package router_pkg;

  localparam logic [5:0] HDR_TAG      = 6'b101010;
  localparam logic [1:0] DEST_INVALID = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HDR,
    ST_PAY,
    ST_PAR,
    ST_GAP
  } framer_state_t;

  function automatic logic [7:0] build_hdr(
    input logic [1:0] dest
  );
    return {HDR_TAG, dest};
  endfunction

endpackage

// File: rtl/router_pkt_framer_if.sv
// router_pkt_framer_if: request, payload and router-side framing bundle.
// err_inj exists only with ROUTER_FRAMER_ERR_INJ_EN.
interface router_pkt_framer_if #(
  parameter int LEN_W = 5
);
  logic             start_valid;
  logic             start_ready;
  logic [1:0]       start_dest;
  logic [LEN_W-1:0] start_len;
  logic             pl_valid;
  logic             pl_ready;
  logic [7:0]       pl_data;
`ifdef ROUTER_FRAMER_ERR_INJ_EN
  logic             err_inj;
`endif
  logic             pkt_valid;
  logic [7:0]       pkt_data;
  logic             pkt_done;
  logic             drop_err;
  logic             busy;

  modport slave (
    input  start_valid, start_dest, start_len,
    input  pl_valid, pl_data,
`ifdef ROUTER_FRAMER_ERR_INJ_EN
    input  err_inj,
`endif
    output start_ready, pl_ready,
    output pkt_valid, pkt_data, pkt_done,
    output drop_err, busy
  );

  modport master (
    output start_valid, start_dest, start_len,
    output pl_valid, pl_data,
`ifdef ROUTER_FRAMER_ERR_INJ_EN
    output err_inj,
`endif
    input  start_ready, pl_ready,
    input  pkt_valid, pkt_data, pkt_done,
    input  drop_err, busy
  );

endinterface

// File: rtl/router_framer_fifo.sv
// router_framer_fifo: show-ahead byte FIFO holding one packet payload;
// pointers wrap modulo DEPTH, cleared by resetn.
module router_framer_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PLAST = AW'(DEPTH - 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;

  // storage write
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wdata;
  end

  // pointer and occupancy tracking
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= (wp == PLAST) ? '0 : wp + 1'b1;
      if (pop)  rp <= (rp == PLAST) ? '0 : rp + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign rdata = mem[rp];
  assign empty = (cnt == '0);

endmodule

// File: rtl/router_pkt_framer.sv
// router_pkt_framer: buffers a whole payload, then frames header/payload/
// parity for router_1x3. ROUTER_FRAMER_ERR_INJ_EN adds parity corruption.
module router_pkt_framer
  import router_pkg::*;
#(
  parameter int LEN_MAX    = 16,
  parameter int LEN_W      = 5,
  parameter int HDR_CYCLES = 2,
  parameter int IPG        = 3
) (
  input logic                 clk,
  input logic                 resetn,
  router_pkt_framer_if.slave  bus
);

  localparam logic [LEN_W-1:0] LMAX  = LEN_W'(LEN_MAX);
  localparam logic [LEN_W-1:0] LONE  = LEN_W'(1);
  localparam logic [3:0]       HLAST = 4'(HDR_CYCLES - 1);
  localparam logic [3:0]       GLAST = 4'(IPG - 1);

  framer_state_t    st;
  logic [7:0]       hdr;
  logic [7:0]       par;
  logic [7:0]       par_out;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] cnt;
  logic [3:0]       tcnt;
  logic             pv_q;
  logic [7:0]       pd_q;
  logic             done_q;
  logic             drop_q;
  logic             req_bad;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic [7:0]       fifo_q;

  assign req_bad = (bus.start_dest == DEST_INVALID) ||
                   (bus.start_len == '0) ||
                   (bus.start_len > LMAX);

  assign push = (st == ST_LOAD) && bus.pl_valid;
  assign pop  = !fifo_empty &&
                (((st == ST_HDR) && (tcnt == '0)) ||
                 ((st == ST_PAY) && (cnt != LONE)));

`ifdef ROUTER_FRAMER_ERR_INJ_EN
  logic inj;

  // error-inject flag captured with the request
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) inj <= 1'b0;
    else if ((st == ST_IDLE) && bus.start_valid)
      inj <= bus.err_inj;
  end

  assign par_out = inj ? ~par : par;
`else
  assign par_out = par;
`endif

  // framing FSM with registered router-side outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st     <= ST_IDLE;
      hdr    <= '0;
      par    <= '0;
      len    <= '0;
      cnt    <= '0;
      tcnt   <= '0;
      pv_q   <= 1'b0;
      pd_q   <= '0;
      done_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      drop_q <= 1'b0;
      unique case (st)
        ST_IDLE: begin
          if (bus.start_valid) begin
            if (req_bad) begin
              drop_q <= 1'b1;
            end else begin
              hdr <= build_hdr(bus.start_dest);
              par <= build_hdr(bus.start_dest);
              len <= bus.start_len;
              cnt <= bus.start_len;
              st  <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (bus.pl_valid) begin
            par <= par ^ bus.pl_data;
            cnt <= cnt - 1'b1;
            if (cnt == LONE) begin
              st   <= ST_HDR;
              tcnt <= HLAST;
              pv_q <= 1'b1;
              pd_q <= hdr;
              cnt  <= len;
            end
          end
        end
        ST_HDR: begin
          if (tcnt == '0) begin
            st   <= ST_PAY;
            pd_q <= fifo_q;
          end else begin
            tcnt <= tcnt - 1'b1;
          end
        end
        ST_PAY: begin
          if (cnt == LONE) begin
            st     <= ST_PAR;
            pv_q   <= 1'b0;
            pd_q   <= par_out;
            done_q <= 1'b1;
          end else begin
            pd_q <= fifo_q;
            cnt  <= cnt - 1'b1;
          end
        end
        ST_PAR: begin
          st   <= ST_GAP;
          pd_q <= '0;
          tcnt <= GLAST;
        end
        ST_GAP: begin
          if (tcnt == '0) st <= ST_IDLE;
          else tcnt <= tcnt - 1'b1;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  router_framer_fifo #(
    .DEPTH (LEN_MAX)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .wdata  (bus.pl_data),
    .rdata  (fifo_q),
    .empty  (fifo_empty)
  );

  assign bus.start_ready = (st == ST_IDLE);
  assign bus.pl_ready    = (st == ST_LOAD);
  assign bus.busy        = (st != ST_IDLE);
  assign bus.pkt_valid   = pv_q;
  assign bus.pkt_data    = pd_q;
  assign bus.pkt_done    = done_q;
  assign bus.drop_err    = drop_q;

endmodule

// File: tb/tb_router_pkt_framer.sv
// tb_router_pkt_framer: directed vectors for the router packet framer.
// Error-inject scenario runs only with ROUTER_FRAMER_ERR_INJ_EN.
module tb_router_pkt_framer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  router_pkt_framer_if #(.LEN_W(5)) bus();

  router_pkt_framer #(
    .LEN_MAX    (16),
    .LEN_W      (5),
    .HDR_CYCLES (2),
    .IPG        (3)
  ) dut (
    .clk    (clk),
    .resetn (rst_n),
    .bus    (bus)
  );

  int vecs = 0;
  int errs = 0;
  int ncyc = 0;

  always @(posedge clk) ncyc <= ncyc + 1;

  // output stream capture
  logic [7:0] ob[$];
  int         first_n = 0;
  int         done_n = 0;
  int         done_cnt = 0;
  int         drop_cnt = 0;
  int         plr_cnt = 0;
  int         bubbles = 0;
  logic [7:0] par_seen = 8'h00;
  logic       pv_done = 1'b0;
  logic       prev_v = 1'b0;
  logic       in_pkt = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_pkt = 1'b0;
    end else begin
      if (bus.pkt_valid && !prev_v) begin
        first_n = ncyc;
        in_pkt = 1'b1;
      end
      if (in_pkt && !bus.pkt_valid && !bus.pkt_done)
        bubbles++;
      if (bus.pkt_valid) ob.push_back(bus.pkt_data);
      if (bus.pkt_done) begin
        done_n = ncyc;
        par_seen = bus.pkt_data;
        pv_done = bus.pkt_valid;
        done_cnt++;
        in_pkt = 1'b0;
      end
      if (bus.drop_err) drop_cnt++;
      if (bus.pl_ready) plr_cnt++;
    end
    prev_v = bus.pkt_valid;
  end

  task automatic req(input logic [1:0] d, input logic [4:0] l);
    int n = 0;
    bus.start_valid = 1'b1;
    bus.start_dest  = d;
    bus.start_len   = l;
    while (!bus.start_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    vecs++;
    if (n >= 200) begin
      errs++;
      $display("FAIL req_accept: start_ready=%b required 1",
               bus.start_ready);
    end
    @(negedge clk);
    bus.start_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b[$], input logic [7:0] pat,
                      input int plen, output int hs_n);
    int i = 0;
    int c = 0;
    hs_n = -100;
    while (i < b.size() && c < 400) begin
      bus.pl_valid = (c < plen) ? pat[c] : 1'b1;
      bus.pl_data  = b[i];
      if (bus.pl_valid && bus.pl_ready) begin
        hs_n = ncyc;
        i++;
      end
      @(negedge clk);
      c++;
    end
    bus.pl_valid = 1'b0;
    vecs++;
    if (i != b.size()) begin
      errs++;
      $display("FAIL pl_accept: accepted %0d required %0d", i, b.size());
    end
  endtask

  task automatic wait_done(input int d0, output bit ok);
    int n = 0;
    while (done_cnt <= d0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = (done_cnt > d0);
  endtask

  task automatic test_reset;
    bus.start_valid = 1'b0;
    bus.start_dest  = 2'd0;
    bus.start_len   = 5'd0;
    bus.pl_valid    = 1'b0;
    bus.pl_data     = 8'h00;
`ifdef ROUTER_FRAMER_ERR_INJ_EN
    bus.err_inj     = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vecs++;
    if ({bus.pkt_valid, bus.pkt_data, bus.pkt_done, bus.drop_err,
         bus.busy, bus.start_ready, bus.pl_ready} !== 14'b0_00000000_00010) begin
      errs++;
      $display("FAIL reset_vals: got v=%b d=%h dn=%b de=%b b=%b sr=%b pr=%b",
               bus.pkt_valid, bus.pkt_data, bus.pkt_done, bus.drop_err,
               bus.busy, bus.start_ready, bus.pl_ready);
      $display("  required v=0 d=00 dn=0 de=0 b=0 sr=1 pr=0");
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vecs++;
    if (bus.busy !== 1'b0 || bus.start_ready !== 1'b1) begin
      errs++;
      $display("FAIL idle_after_reset: busy=%b sr=%b required 0 1",
               bus.busy, bus.start_ready);
    end
  endtask

  task automatic test_basic;
    logic [7:0] q[$];
    logic [7:0] e[$];
    int d0, s, hs, b0, n;
    bit ok;
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    e = '{8'hAA, 8'hAA, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    d0 = done_cnt; s = ob.size(); b0 = bubbles;
    req(2'd2, 5'd5);
    send(q, 8'h01, 0, hs);
    wait_done(d0, ok);
    vecs++;
    if (!ok) begin errs++; $display("FAIL basic_done: no pkt_done"); end
    vecs++;
    if (ob.size() - s != 7) begin
      errs++;
      $display("FAIL basic_count: got %0d required 7", ob.size() - s);
    end
    for (int i = 0; i < 7; i++) begin
      vecs++;
      if (s + i >= ob.size() || ob[s+i] !== e[i]) begin
        errs++;
        $display("FAIL basic_byte%0d: got %h required %h", i, ob[s+i], e[i]);
      end
    end
    vecs++;
    if (par_seen !== 8'hBB || pv_done !== 1'b0) begin
      errs++;
      $display("FAIL basic_parity: got %h v=%b required bb v=0",
               par_seen, pv_done);
    end
    vecs++;
    if (first_n != hs + 1) begin
      errs++;
      $display("FAIL basic_latency: hdr at %0d required %0d", first_n, hs + 1);
    end
    vecs++;
    if (done_n != first_n + 7) begin
      errs++;
      $display("FAIL basic_span: done at %0d required %0d", done_n, first_n + 7);
    end
    vecs++;
    if (bubbles != b0) begin
      errs++;
      $display("FAIL basic_bubble: got %0d gaps required 0", bubbles - b0);
    end
    n = 0;
    while (!bus.start_ready && n < 50) begin @(negedge clk); n++; end
    vecs++;
    if (ncyc != done_n + 4) begin
      errs++;
      $display("FAIL basic_ipg: ready at %0d required %0d", ncyc, done_n + 4);
    end
  endtask

  task automatic test_drop;
    int d0, p0, s;
    d0 = drop_cnt; p0 = plr_cnt; s = ob.size();
    req(2'd3, 5'd4);
    repeat (4) @(negedge clk);
    vecs++;
    if (drop_cnt - d0 != 1) begin
      errs++;
      $display("FAIL drop_dest3: pulses %0d required 1", drop_cnt - d0);
    end
    vecs++;
    if (plr_cnt != p0 || ob.size() != s || bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL drop_quiet: pl_ready %0d bytes %0d busy %b required 0 0 0",
               plr_cnt - p0, ob.size() - s, bus.busy);
    end
    req(2'd0, 5'd0);
    repeat (2) @(negedge clk);
    req(2'd1, 5'd17);
    repeat (2) @(negedge clk);
    vecs++;
    if (drop_cnt - d0 != 3 || plr_cnt != p0) begin
      errs++;
      $display("FAIL drop_len: pulses %0d pl_ready %0d required 3 0",
               drop_cnt - d0, plr_cnt - p0);
    end
  endtask

  task automatic test_stall;
    logic [7:0] q[$];
    logic [7:0] e[$];
    int d0, s, hs, b0;
    bit ok;
    q = '{8'h5A, 8'hC3, 8'h0F};
    e = '{8'hA8, 8'hA8, 8'h5A, 8'hC3, 8'h0F};
    d0 = done_cnt; s = ob.size(); b0 = bubbles;
    req(2'd0, 5'd3);
    send(q, 8'b0010_1001, 6, hs);
    wait_done(d0, ok);
    vecs++;
    if (!ok || ob.size() - s != 5) begin
      errs++;
      $display("FAIL stall_count: done=%b bytes %0d required 1 5",
               ok, ob.size() - s);
    end
    for (int i = 0; i < 5; i++) begin
      vecs++;
      if (s + i >= ob.size() || ob[s+i] !== e[i]) begin
        errs++;
        $display("FAIL stall_byte%0d: got %h required %h", i, ob[s+i], e[i]);
      end
    end
    vecs++;
    if (par_seen !== 8'h3E) begin
      errs++;
      $display("FAIL stall_parity: got %h required 3e", par_seen);
    end
    vecs++;
    if (bubbles != b0 || first_n != hs + 1) begin
      errs++;
      $display("FAIL stall_timing: gaps %0d hdr at %0d required 0 %0d",
               bubbles - b0, first_n, hs + 1);
    end
  endtask

  task automatic test_full;
    logic [7:0] q[$];
    int d0, s, hs, b0, bad;
    bit ok;
    for (int i = 0; i < 16; i++) q.push_back(8'hFF);
    d0 = done_cnt; s = ob.size(); b0 = bubbles;
    req(2'd2, 5'd16);
    send(q, 8'h01, 0, hs);
    wait_done(d0, ok);
    vecs++;
    if (!ok || ob.size() - s != 18) begin
      errs++;
      $display("FAIL full_count: done=%b bytes %0d required 1 18",
               ok, ob.size() - s);
    end
    bad = 0;
    for (int i = 0; i < 18; i++)
      if (s + i >= ob.size() || ob[s+i] !== ((i < 2) ? 8'hAA : 8'hFF))
        bad++;
    vecs++;
    if (bad != 0) begin
      errs++;
      $display("FAIL full_bytes: %0d wrong bytes required 0", bad);
    end
    vecs++;
    if (par_seen !== 8'hAA || done_n != first_n + 18 || bubbles != b0) begin
      errs++;
      $display("FAIL full_tail: par %h span %0d gaps %0d required aa 18 0",
               par_seen, done_n - first_n, bubbles - b0);
    end
  endtask

`ifdef ROUTER_FRAMER_ERR_INJ_EN
  task automatic test_err_inj;
    logic [7:0] q[$];
    logic [7:0] e[$];
    int d0, s, hs;
    bit ok;
    q = '{8'h00};
    e = '{8'hA9, 8'hA9, 8'h00};
    d0 = done_cnt; s = ob.size();
    bus.err_inj = 1'b1;
    req(2'd1, 5'd1);
    bus.err_inj = 1'b0;
    send(q, 8'h01, 0, hs);
    wait_done(d0, ok);
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (s + i >= ob.size() || ob[s+i] !== e[i]) begin
        errs++;
        $display("FAIL inj_byte%0d: got %h required %h", i, ob[s+i], e[i]);
      end
    end
    vecs++;
    if (!ok || par_seen !== 8'h56) begin
      errs++;
      $display("FAIL inj_parity: done=%b got %h required 56", ok, par_seen);
    end
  endtask
`endif

  task automatic test_reset_mid;
    logic [7:0] q[$];
    logic [7:0] e[$];
    int d0, s, hs, n;
    bit ok;
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    s = ob.size();
    req(2'd2, 5'd8);
    send(q, 8'h01, 0, hs);
    n = 0;
    while (ob.size() - s < 4 && n < 50) begin @(negedge clk); n++; end
    vecs++;
    if (bus.pkt_valid !== 1'b1) begin
      errs++;
      $display("FAIL rst_pre: pkt_valid=%b required 1", bus.pkt_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    vecs++;
    if (bus.pkt_valid !== 1'b0 || bus.pkt_data !== 8'h00 ||
        bus.busy !== 1'b0 || bus.start_ready !== 1'b1) begin
      errs++;
      $display("FAIL rst_async: v=%b d=%h busy=%b sr=%b required 0 00 0 1",
               bus.pkt_valid, bus.pkt_data, bus.busy, bus.start_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    q = '{8'h01, 8'h02};
    e = '{8'hA9, 8'hA9, 8'h01, 8'h02};
    d0 = done_cnt; s = ob.size();
    req(2'd1, 5'd2);
    send(q, 8'h01, 0, hs);
    wait_done(d0, ok);
    vecs++;
    if (!ok || ob.size() - s != 4) begin
      errs++;
      $display("FAIL post_rst_count: done=%b bytes %0d required 1 4",
               ok, ob.size() - s);
    end
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (s + i >= ob.size() || ob[s+i] !== e[i]) begin
        errs++;
        $display("FAIL post_rst_byte%0d: got %h required %h",
                 i, ob[s+i], e[i]);
      end
    end
    vecs++;
    if (par_seen !== 8'hAA) begin
      errs++;
      $display("FAIL post_rst_parity: got %h required aa", par_seen);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_drop();
    test_stall();
    test_full();
`ifdef ROUTER_FRAMER_ERR_INJ_EN
    test_err_inj();
`endif
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
